// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// matmul_pkg : shared types and helpers for the matmul engine arbiter
// Rev 1.0
// ============================================================================
package matmul_pkg;

    localparam int MAX_REQ             = 8;
    localparam int MAX_IDX_W           = 3;
    localparam int DEFAULT_TIMEOUT_CYC = 4096;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // First set bit of mask at or after ptr, wrapping at n (n <= MAX_REQ).
    // Scanning downward lets the smallest rotated offset win.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   mask,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input int                   n);
        pick_t r;
        int    j;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (mask[j[MAX_IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[MAX_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// rr_picker : combinational rotate-priority encoder over one request class
// Rev 1.0
// ============================================================================
module rr_picker
    import matmul_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         mask,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    found,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int SEL_W = $clog2(NREQ);

    logic [MAX_REQ-1:0]   w_mask;
    logic [MAX_IDX_W-1:0] w_ptr;
    pick_t                w_pick;

    always_comb begin
        w_mask             = '0;
        w_mask[NREQ-1:0]   = mask;
        w_ptr              = '0;
        w_ptr[SEL_W-1:0]   = ptr;
        w_pick             = rr_pick(w_mask, w_ptr, NREQ);
        found              = w_pick.found;
        idx                = w_pick.idx[SEL_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/matmul_arbiter.sv
`default_nettype none
// ============================================================================
// matmul_arbiter : two-class round-robin arbiter sequencing a shared matmul
//                  engine, with start/done handshake and hang watchdog
// Rev 1.0
// ============================================================================
module matmul_arbiter
    import matmul_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         hi_prio,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         req_done,
    output logic [NREQ-1:0]         req_err,
    output logic                    mm_start,
    input  logic                    mm_done,
    output logic [$clog2(NREQ)-1:0] mm_sel,
    output logic                    busy,
    output logic [CNT_W-1:0]        txn_count
);

    localparam int SEL_W = $clog2(NREQ);
    localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0]  c_wd_last  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [SEL_W-1:0] c_sel_last = SEL_W'(NREQ - 1);

    arb_state_e       r_state, w_state_nxt;
    logic [NREQ-1:0]  r_gnt,   w_gnt_nxt;
    logic [SEL_W-1:0] r_sel,   w_sel_nxt;
    logic [SEL_W-1:0] r_ptr,   w_ptr_nxt;
    logic [WD_W-1:0]  r_wd,    w_wd_nxt;
    logic             r_ok,    w_ok_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_done_q;

    logic             w_hi_found, w_lo_found;
    logic [SEL_W-1:0] w_hi_idx,   w_lo_idx;
    logic             w_complete;

    rr_picker #(.NREQ(NREQ)) u_pick_hi (
        .mask  (req & hi_prio),
        .ptr   (r_ptr),
        .found (w_hi_found),
        .idx   (w_hi_idx)
    );

    rr_picker #(.NREQ(NREQ)) u_pick_lo (
        .mask  (req & ~hi_prio),
        .ptr   (r_ptr),
        .found (w_lo_found),
        .idx   (w_lo_idx)
    );

    // Only a fresh rising edge counts, so a done level left over from an
    // earlier job can never complete the current one.
    assign w_complete = mm_done & ~r_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_sel    <= '0;
            r_ptr    <= '0;
            r_wd     <= '0;
            r_ok     <= 1'b0;
            r_cnt    <= '0;
            r_done_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_sel    <= w_sel_nxt;
            r_ptr    <= w_ptr_nxt;
            r_wd     <= w_wd_nxt;
            r_ok     <= w_ok_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done_q <= mm_done;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_wd_nxt    = r_wd;
        w_ok_nxt    = r_ok;
        w_cnt_nxt   = r_cnt;
        mm_start    = 1'b0;
        req_done    = '0;
        req_err     = '0;
        case (r_state)
            IDLE: begin
                if (w_hi_found || w_lo_found) begin
                    w_sel_nxt   = w_hi_found ? w_hi_idx : w_lo_idx;
                    w_gnt_nxt   = NREQ'(1) << w_sel_nxt;
                    w_wd_nxt    = '0;
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                if (!mm_done) begin
                    mm_start    = 1'b1;
                    w_wd_nxt    = '0;
                    w_state_nxt = WAIT;
                end else if (r_wd == c_wd_last) begin
                    w_ok_nxt    = 1'b0;
                    w_state_nxt = RELEASE;
                end else begin
                    w_wd_nxt    = r_wd + WD_W'(1);
                end
            end
            WAIT: begin
                if (w_complete) begin
                    w_ok_nxt    = 1'b1;
                    w_state_nxt = RELEASE;
                end else if (r_wd == c_wd_last) begin
                    w_ok_nxt    = 1'b0;
                    w_state_nxt = RELEASE;
                end else begin
                    w_wd_nxt    = r_wd + WD_W'(1);
                end
            end
            RELEASE: begin
                if (r_ok) begin
                    req_done = r_gnt;
                    if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    req_err = r_gnt;
                end
                w_gnt_nxt   = '0;
                w_ptr_nxt   = (r_sel == c_sel_last) ? '0 : r_sel + SEL_W'(1);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign gnt       = r_gnt;
    assign mm_sel    = r_sel;
    assign busy      = (r_state != IDLE);
    assign txn_count = r_cnt;

endmodule
`default_nettype wire
